// File: rtl/bg_pkg.sv
// bg_pkg: shared types for the bandgap trim-code capture block.
`default_nettype none

package bg_pkg;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } bg_state_e;

  typedef struct packed {
    logic [7:0] coarse;
    logic [7:0] fine;
  } bg_code_t;

  localparam int TMR_W = 13;

endpackage

`default_nettype wire

// File: rtl/bg_code_cmp.sv
// bg_code_cmp: combinational consistency check of a sample against a reference code.
`default_nettype none

module bg_code_cmp
  import bg_pkg::*;
#(
  parameter int FINE_TOL = 2
) (
  input  bg_code_t sample,
  input  bg_code_t ref_code,
  output logic     consistent
);

  logic signed [8:0] fine_diff;
  logic        [8:0] fine_mag;

  // 9-bit signed difference so the magnitude never wraps across 0/255
  always_comb begin
    fine_diff  = $signed({1'b0, sample.fine}) - $signed({1'b0, ref_code.fine});
    fine_mag   = fine_diff[8] ? $unsigned(-fine_diff) : $unsigned(fine_diff);
    consistent = (sample.coarse == ref_code.coarse) && (fine_mag <= 9'(FINE_TOL));
  end

endmodule

`default_nettype wire

// File: rtl/bg_code_capture.sv
// bg_code_capture: qualifies SAR trim codes, locks, monitors drift, hands off via req/ack.
// Optional macro BG_CODE_CAPTURE_AVG_EN: locked fine code is the rounded run average.
`default_nettype none

module bg_code_capture
  import bg_pkg::*;
#(
  parameter int LOCK_CNT    = 4,
  parameter int FINE_TOL    = 2,
  parameter int DRIFT_CNT   = 3,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pwrup,
  input  logic        valid,
  input  logic [7:0]  idacCoarse,
  input  logic [7:0]  idacFine,
  input  logic        err_clr,
  input  logic        code_ack,
  output logic [15:0] code_out,
  output logic        code_req,
  output logic        locked,
  output logic        drift_err,
  output logic        timeout,
  output logic [1:0]  state
);

  bg_state_e          st;
  logic               valid_q;
  logic               has_ref;
  bg_code_t           ref_code;
  logic [4:0]         match_cnt;
  logic [7:0]         drift_cnt;
  logic [TMR_W-1:0]   tmr;

  bg_code_t           sample;
  bg_code_t           cmp_ref;
  logic               consistent;
  logic               sample_evt;
  logic               ref_load;
  logic               run_inc;
  logic [7:0]         lock_fine;

  assign sample     = '{coarse: idacCoarse, fine: idacFine};
  assign sample_evt = valid & ~valid_q;
  assign cmp_ref    = (st == ST_LOCKED) ? bg_code_t'(code_out) : ref_code;
  assign ref_load   = (st == ST_ACQ) && sample_evt && (!has_ref || !consistent);
  assign run_inc    = (st == ST_ACQ) && sample_evt && has_ref && consistent;
  assign state      = st;

  bg_code_cmp #(.FINE_TOL(FINE_TOL)) u_cmp (
    .sample     (sample),
    .ref_code   (cmp_ref),
    .consistent (consistent)
  );

`ifdef BG_CODE_CAPTURE_AVG_EN
  localparam int ACC_W     = 12;
  localparam int AVG_SHIFT = $clog2(LOCK_CNT);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;

  assign acc_sum   = acc + ACC_W'(sample.fine);
  assign lock_fine = 8'((acc_sum + ACC_W'(LOCK_CNT / 2)) >> AVG_SHIFT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (!pwrup) begin
      acc <= '0;
    end else if (ref_load) begin
      acc <= ACC_W'(sample.fine);
    end else if (run_inc) begin
      acc <= acc_sum;
    end
  end
`else
  assign lock_fine = sample.fine;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st        <= ST_OFF;
      valid_q   <= 1'b0;
      has_ref   <= 1'b0;
      ref_code  <= '0;
      match_cnt <= '0;
      drift_cnt <= '0;
      tmr       <= '0;
      code_out  <= '0;
      code_req  <= 1'b0;
      locked    <= 1'b0;
      drift_err <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      valid_q <= valid;
      // Clear first so a same-cycle set event below takes priority
      if (err_clr) begin
        drift_err <= 1'b0;
        timeout   <= 1'b0;
      end
      if (!pwrup) begin
        st        <= ST_OFF;
        locked    <= 1'b0;
        code_req  <= 1'b0;
        has_ref   <= 1'b0;
        match_cnt <= '0;
        drift_cnt <= '0;
        tmr       <= '0;
      end else begin
        if (st == ST_OFF || sample_evt) begin
          tmr <= '0;
        end else if (tmr != TMR_W'(TIMEOUT_CYC)) begin
          tmr <= tmr + 1'b1;
          if (tmr == TMR_W'(TIMEOUT_CYC - 1)) timeout <= 1'b1;
        end

        if (code_req && code_ack) code_req <= 1'b0;

        case (st)
          ST_OFF: begin
            st        <= ST_ACQ;
            has_ref   <= 1'b0;
            match_cnt <= '0;
          end
          ST_ACQ: begin
            if (ref_load) begin
              ref_code  <= sample;
              has_ref   <= 1'b1;
              match_cnt <= 5'd1;
            end else if (run_inc) begin
              match_cnt <= match_cnt + 5'd1;
              if (match_cnt == 5'(LOCK_CNT - 1)) begin
                st        <= ST_LOCKED;
                code_out  <= {sample.coarse, lock_fine};
                locked    <= 1'b1;
                code_req  <= 1'b1;
                drift_cnt <= '0;
              end
            end
          end
          ST_LOCKED: begin
            if (sample_evt) begin
              if (consistent) begin
                drift_cnt <= '0;
              end else if (drift_cnt == 8'(DRIFT_CNT - 1)) begin
                st        <= ST_ACQ;
                locked    <= 1'b0;
                code_req  <= 1'b0;
                drift_err <= 1'b1;
                has_ref   <= 1'b0;
                match_cnt <= '0;
                drift_cnt <= '0;
              end else begin
                drift_cnt <= drift_cnt + 8'd1;
              end
            end
          end
          default: st <= ST_OFF;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bg_code_capture.sv
// tb_bg_code_capture: scoreboard-driven self-checking bench for bg_code_capture.
`default_nettype none

module tb_bg_code_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pwrup;
  logic        valid;
  logic [7:0]  idacCoarse;
  logic [7:0]  idacFine;
  logic        err_clr;
  logic        code_ack;
  logic [15:0] code_out;
  logic        code_req;
  logic        locked;
  logic        drift_err;
  logic        timeout;
  logic [1:0]  state;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sbq[$];

  always #50 clk = ~clk;

  bg_code_capture dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pwrup      (pwrup),
    .valid      (valid),
    .idacCoarse (idacCoarse),
    .idacFine   (idacFine),
    .err_clr    (err_clr),
    .code_ack   (code_ack),
    .code_out   (code_out),
    .code_req   (code_req),
    .locked     (locked),
    .drift_err  (drift_err),
    .timeout    (timeout),
    .state      (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sbq.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_rise(input logic [15:0] c);
    idacCoarse = c[15:8];
    idacFine   = c[7:0];
    valid      = 1'b1;
    tick();
  endtask

  task automatic pulse_fall();
    valid = 1'b0;
    tick();
  endtask

  task automatic send(input logic [15:0] c);
    pulse_rise(c);
    pulse_fall();
  endtask

  // Expected locked code for a four-sample run with coarse 0x8A
  function automatic logic [15:0] exp_lock4(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c, input logic [7:0] d);
    int s;
    s = int'(a) + int'(b) + int'(c) + int'(d);
`ifdef BG_CODE_CAPTURE_AVG_EN
    return {8'h8A, 8'((s + 2) >> 2)};
`else
    if (s < 0) return 16'h0;
    return {8'h8A, d};
`endif
  endfunction

  logic [15:0] exp_b;

  initial begin
    reset_n = 1'b0; pwrup = 1'b0; valid = 1'b0; idacCoarse = '0; idacFine = '0;
    err_clr = 1'b0; code_ack = 1'b0;
    tick(2);
    sb_push("rst_code", 0); sb_push("rst_req", 0); sb_push("rst_locked", 0);
    sb_push("rst_drift", 0); sb_push("rst_timeout", 0); sb_push("rst_state", 0);
    sb_check(code_out); sb_check(code_req); sb_check(locked);
    sb_check(drift_err); sb_check(timeout); sb_check(state);
    reset_n = 1'b1;
    tick();

    // Power up -> ACQ
    pwrup = 1'b1;
    sb_push("pwrup_state", 1);
    tick();
    sb_check(state);

    // Four identical samples lock
    send(16'h8A35); send(16'h8A35); send(16'h8A35);
    sb_push("A_prelock", 0);
    sb_check(locked);
    sb_push("A_locked", 1); sb_push("A_code", 16'h8A35); sb_push("A_req", 1); sb_push("A_state", 2);
    pulse_rise(16'h8A35);
    sb_check(locked); sb_check(code_out); sb_check(code_req); sb_check(state);
    pulse_fall();
    code_ack = 1'b1;
    sb_push("A_ack_req", 0);
    tick();
    sb_check(code_req);
    sb_push("A_ack_idle_req", 0); sb_push("A_ack_idle_locked", 1);
    tick();
    sb_check(code_req); sb_check(locked);
    code_ack = 1'b0;

    // Drift: three far samples drop lock
    send(16'h8A40); send(16'h8A40);
    sb_push("D_still_locked", 1);
    sb_check(locked);
    sb_push("D_locked", 0); sb_push("D_err", 1); sb_push("D_state", 1); sb_push("D_code_hold", 16'h8A35);
    pulse_rise(16'h8A40);
    sb_check(locked); sb_check(drift_err); sb_check(state); sb_check(code_out);
    pulse_fall();
    err_clr = 1'b1;
    sb_push("D_clr", 0);
    tick();
    sb_check(drift_err);
    err_clr = 1'b0;

    // In-tolerance run locks (last sample or rounded average)
    exp_b = exp_lock4(8'h35, 8'h37, 8'h33, 8'h34);
    send(16'h8A35); send(16'h8A37); send(16'h8A33);
    sb_push("B_locked", 1); sb_push("B_code", exp_b); sb_push("B_req", 1);
    pulse_rise(16'h8A34);
    sb_check(locked); sb_check(code_out); sb_check(code_req);
    pulse_fall();

    // Power-down with req pending
    pwrup = 1'b0;
    sb_push("P_state", 0); sb_push("P_locked", 0); sb_push("P_req", 0); sb_push("P_code", exp_b);
    tick();
    sb_check(state); sb_check(locked); sb_check(code_req); sb_check(code_out);
    pwrup = 1'b1;
    tick();

    // Coarse change restarts the run
    send(16'h8A35); send(16'h8A35); send(16'h8B35); send(16'h8B35); send(16'h8B35);
    sb_push("C_not_locked", 0); sb_push("C_state", 1);
    sb_check(locked); sb_check(state);
    sb_push("C_locked", 1); sb_push("C_code", 16'h8B35);
    pulse_rise(16'h8B35);
    sb_check(locked); sb_check(code_out);
    pulse_fall();
    code_ack = 1'b1;
    tick();
    code_ack = 1'b0;

    // Timeout in ACQ
    pwrup = 1'b0; tick();
    pwrup = 1'b1; tick();
    tick(4095);
    sb_push("T_before", 0);
    sb_check(timeout);
    sb_push("T_set", 1);
    tick();
    sb_check(timeout);
    sb_push("T_sticky", 1);
    pulse_rise(16'h1234);
    sb_check(timeout);
    pulse_fall();
    err_clr = 1'b1;
    sb_push("T_clr", 0);
    tick();
    sb_check(timeout);
    err_clr = 1'b0;
    tick(4093);
    sb_push("T_restart_before", 0);
    sb_check(timeout);
    sb_push("T_restart_set", 1);
    tick();
    sb_check(timeout);

    // Asynchronous reset mid-ACQ, away from a clock edge
    sb_push("R_state_pre", 1);
    sb_check(state);
    reset_n = 1'b0;
    #5;
    sb_push("R_code", 0); sb_push("R_state", 0); sb_push("R_timeout", 0); sb_push("R_req", 0);
    sb_check(code_out); sb_check(state); sb_check(timeout); sb_check(code_req);

    chk("sb_leftover", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
